// File: rtl/br_comp.sv
// ---------------------------------------------------------------------------
// br_comp: branch comparator for the RV32I execute stage.
//
// Reports whether rs1 is less than rs2 and whether the two are equal, so
// branch decisions (BEQ/BNE/BLT/BGE/BLTU/BGEU) resolve in the same cycle.
// Registered copies of both flags are kept for later pipeline stages or debug.
//
// Ports:
//   clk_i       clock, used only by the registered flag copies
//   rst_i       asynchronous active-high reset, clears the registered copies
//   rs1_data    first operand
//   rs2_data    second operand
//   br_unsigned 1 = unsigned compare, 0 = signed two's complement compare
//   br_less     rs1 < rs2 under the selected signedness (combinational)
//   br_equal    rs1 == rs2 bit-for-bit (combinational)
//   br_less_q   br_less registered on rising clk_i
//   br_equal_q  br_equal registered on rising clk_i
// ---------------------------------------------------------------------------
module br_comp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             br_unsigned,
  output logic             br_less,
  output logic             br_equal,
  output logic             br_less_q,
  output logic             br_equal_q
);

  // The tree is built over WIDTH rounded up to a power of two; the padding
  // leaves compare as equal so they never influence the result.
  localparam int LVLS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW   = 1 << LVLS;
  localparam int NN   = 2 * PW - 1;

  // Heap-ordered node arrays: node n has children 2n+1 (more significant
  // half) and 2n+2 (less significant half). Leaves sit at PW-1 .. 2*PW-2,
  // with the MSB leaf first. Equality of a node is "neither lt nor gt".
  logic [NN-1:0] lt_n;
  logic [NN-1:0] gt_n;

  genvar k;
  generate
    for (k = 0; k < PW; k++) begin : g_leaf
      if ((PW - 1 - k) < WIDTH) begin : g_real
        assign lt_n[PW-1+k] = ~rs1_data[PW-1-k] &  rs2_data[PW-1-k];
        assign gt_n[PW-1+k] =  rs1_data[PW-1-k] & ~rs2_data[PW-1-k];
      end else begin : g_pad
        assign lt_n[PW-1+k] = 1'b0;
        assign gt_n[PW-1+k] = 1'b0;
      end
    end

    // Merge pairwise: the more significant half decides unless it is equal.
    for (k = 0; k < PW - 1; k++) begin : g_node
      assign lt_n[k] = lt_n[2*k+1] | (~gt_n[2*k+1] & lt_n[2*k+2]);
      assign gt_n[k] = gt_n[2*k+1] | (~lt_n[2*k+1] & gt_n[2*k+2]);
    end
  endgenerate

  logic u_less;
  logic sign_diff;
  logic br_less_d;
  logic br_equal_d;

  assign u_less    = lt_n[0];
  assign sign_diff = rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1];

  always_comb begin
    br_equal = ~(lt_n[0] | gt_n[0]);
    // Signed with differing signs: rs1 is less exactly when it is negative.
    if (!br_unsigned && sign_diff) begin
      br_less = rs1_data[WIDTH-1];
    end else begin
      br_less = u_less;
    end
    br_less_d  = br_less;
    br_equal_d = br_equal;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_less_q  <= 1'b0;
      br_equal_q <= 1'b0;
    end else begin
      br_less_q  <= br_less_d;
      br_equal_q <= br_equal_d;
    end
  end

endmodule

// File: tb/tb_br_comp.sv
module tb_br_comp;

  localparam int WIDTH = 32;

  logic             clk_i;
  logic             rst_i;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             br_unsigned;
  logic             br_less;
  logic             br_equal;
  logic             br_less_q;
  logic             br_equal_q;

  int checks;
  int failures;

  br_comp #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .br_unsigned(br_unsigned),
    .br_less    (br_less),
    .br_equal   (br_equal),
    .br_less_q  (br_less_q),
    .br_equal_q (br_equal_q)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic        exp_less;
    logic        exp_equal;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (rs1=%h rs2=%h uns=%b)",
               name, act, exp, rs1_data, rs2_data, br_unsigned);
    end
  endtask

  // Reference: plain arithmetic on the specification's rules.
  function automatic logic ref_less(input logic [31:0] a, input logic [31:0] b,
                                    input logic uns);
    if (uns) return (a < b);
    return ($signed(a) < $signed(b));
  endfunction

  task automatic add(input logic [31:0] a, input logic [31:0] b,
                     input logic uns, input logic l, input logic e);
    vec_t v;
    v.a = a; v.b = b; v.uns = uns; v.exp_less = l; v.exp_equal = e;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i       = 1'b1;
    rs1_data    = 32'h0;
    rs2_data    = 32'h0;
    br_unsigned = 1'b0;

    for (int u = 0; u < 2; u++) begin
      add(32'h12345678, 32'h01234567, u[0], 1'b0, 1'b0);
      add(32'h01234567, 32'h12345678, u[0], 1'b1, 1'b0);
      add(32'h89ABCDEF, 32'h87654321, u[0], 1'b0, 1'b0);
      add(32'h87654321, 32'h89ABCDEF, u[0], 1'b1, 1'b0);
      add(32'h01234567, 32'h01234567, u[0], 1'b0, 1'b1);
      add(32'h89ABCDEF, 32'h89ABCDEF, u[0], 1'b0, 1'b1);
      add(32'h00000000, 32'h00000000, u[0], 1'b0, 1'b1);
      add(32'hFFFFFFFF, 32'hFFFFFFFF, u[0], 1'b0, 1'b1);
    end
    add(32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0);
    add(32'h01234567, 32'h89ABCDEF, 1'b1, 1'b1, 1'b0);
    add(32'h89ABCDEF, 32'h01234567, 1'b0, 1'b1, 1'b0);
    add(32'h89ABCDEF, 32'h01234567, 1'b1, 1'b0, 1'b0);
    add(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    add(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0);
    add(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0);
    add(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
    add(32'h00000000, 32'h00000001, 1'b1, 1'b1, 1'b0);

    // Reset state: registered copies held low, combinational flags still live.
    #2;
    chk("rst_less_q", br_less_q, 1'b0);
    chk("rst_equal_q", br_equal_q, 1'b0);
    chk("rst_comb_equal", br_equal, 1'b1);
    chk("rst_comb_less", br_less, 1'b0);
    @(posedge clk_i); #1;
    chk("rst_hold_equal_q", br_equal_q, 1'b0);

    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed table: combinational result, then registered copy after edge.
    foreach (vecs[i]) begin
      @(negedge clk_i);
      rs1_data = vecs[i].a; rs2_data = vecs[i].b; br_unsigned = vecs[i].uns;
      #1;
      chk($sformatf("vec%0d_less", i), br_less, vecs[i].exp_less);
      chk($sformatf("vec%0d_equal", i), br_equal, vecs[i].exp_equal);
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d_less_q", i), br_less_q, vecs[i].exp_less);
      chk($sformatf("vec%0d_equal_q", i), br_equal_q, vecs[i].exp_equal);
    end

    // Toggle signedness with operands held; no clock edge between changes.
    @(negedge clk_i);
    rs1_data = 32'h01234567; rs2_data = 32'h89ABCDEF;
    for (int t = 0; t < 4; t++) begin
      br_unsigned = t[0];
      #1;
      chk($sformatf("toggle%0d_less", t), br_less, t[0]);
      chk($sformatf("toggle%0d_equal", t), br_equal, 1'b0);
    end

    // Randomized against the reference model.
    for (int r = 0; r < 400; r++) begin
      logic [31:0] a, b;
      logic        u;
      @(negedge clk_i);
      a = $urandom; b = $urandom; u = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        2: b = {a[31], b[30:0]};
        default: ;
      endcase
      rs1_data = a; rs2_data = b; br_unsigned = u;
      #1;
      chk("rand_less", br_less, ref_less(a, b, u));
      chk("rand_equal", br_equal, a == b);
      @(posedge clk_i); #1;
      chk("rand_less_q", br_less_q, ref_less(a, b, u));
      chk("rand_equal_q", br_equal_q, a == b);
    end

    // Async reset mid-operation while registered less is 1.
    @(negedge clk_i);
    rs1_data = 32'h01234567; rs2_data = 32'h12345678; br_unsigned = 1'b0;
    @(posedge clk_i); #1;
    chk("pre_rst_less_q", br_less_q, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_less_q", br_less_q, 1'b0);
    chk("async_rst_equal_q", br_equal_q, 1'b0);
    chk("async_rst_comb_less", br_less, 1'b1);
    @(posedge clk_i); #1;
    chk("rst_edge_less_q", br_less_q, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post_release_less_q", br_less_q, 1'b0);
    @(posedge clk_i); #1;
    chk("first_edge_less_q", br_less_q, 1'b1);
    chk("first_edge_equal_q", br_equal_q, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
